// File: rtl/node_mem_pkg.sv
// Shared types and helpers for the node memory: FSM states, byte merge, range check.
package node_mem_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      CLEAR = 2'd1,
      IDLE  = 2'd2
   } fsm_state_e;

   // Widest word the merge helper handles; callers zero-extend and truncate.
   localparam int unsigned MERGE_W = 512;

   function automatic logic [MERGE_W-1:0] byte_merge(input logic [MERGE_W-1:0]   old_w,
                                                     input logic [MERGE_W-1:0]   new_w,
                                                     input logic [MERGE_W/8-1:0] be);
      logic [MERGE_W-1:0] res;
      res = old_w;
      for (int i = 0; i < MERGE_W / 8; i++) begin
         if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
      end
      return res;
   endfunction

   function automatic logic in_range(input logic [63:0] addr, input int unsigned depth);
      return addr < 64'(depth);
   endfunction

endpackage

// File: rtl/node_ram_ctrl_if.sv
// Main port, peek port and clear/status bundle of the node memory.
interface node_ram_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   import node_mem_pkg::*;

   // Strobes (we, re, peek_req, clr_req) are sampled on every edge with no ready;
   // rvalid/peek_valid/err are single-cycle pulses, and all main-port strobes are dropped while busy.
   logic                  clr_req;
   logic                  busy;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   be;
   logic                  we;
   logic                  re;
   logic [DATA_W-1:0]     rdata;
   logic                  rvalid;
   logic                  err;
   logic [ADDR_W-1:0]     peek_addr;
   logic                  peek_req;
   logic [DATA_W-1:0]     peek_data;
   logic                  peek_valid;
   fsm_state_e            state;

   modport master (
      output clr_req, addr, wdata, be, we, re, peek_addr, peek_req,
      input  busy, rdata, rvalid, err, peek_data, peek_valid, state
   );

   modport slave (
      input  clr_req, addr, wdata, be, we, re, peek_addr, peek_req,
      output busy, rdata, rvalid, err, peek_data, peek_valid, state
   );

endinterface

// File: rtl/node_ram_array.sv
// Inferred block RAM: byte-enabled read-first port A plus read-only port B, latency 1.
module node_ram_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int AW     = 10
) (
   input  logic                clk,
   input  logic                a_en,
   input  logic                a_we,
   input  logic [DATA_W/8-1:0] a_be,
   input  logic [AW-1:0]       a_addr,
   input  logic [DATA_W-1:0]   a_wdata,
   output logic [DATA_W-1:0]   a_rdata,
   input  logic                b_en,
   input  logic [AW-1:0]       b_addr,
   output logic [DATA_W-1:0]   b_rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] a_rdata_q;
   logic [DATA_W-1:0] b_rdata_q;

   always_ff @(posedge clk) begin
      if (a_en) begin
         a_rdata_q <= mem[a_addr];
         if (a_we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
               if (a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
         end
      end
      if (b_en) b_rdata_q <= mem[b_addr];
   end

   assign a_rdata = a_rdata_q;
   assign b_rdata = b_rdata_q;

endmodule

// File: rtl/node_ram_ctrl.sv
// Node memory controller: clear engine FSM, range checks, write-first bypass and
// optional output register around node_ram_array.
module node_ram_ctrl
   import node_mem_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 1024,
   parameter int ADDR_W    = 32,
   parameter int OUT_REG   = 0,
   parameter int WR_FIRST  = 0,
   parameter int INIT_ZERO = 1
) (
   input  logic            clk,
   input  logic            rst,
   node_ram_ctrl_if.slave  bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW = DATA_W / 8;

   fsm_state_e        state_q, state_d;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic              main_ok, main_inr, peek_inr;

   logic              ram_a_en, ram_a_we, ram_b_en;
   logic [BW-1:0]     ram_a_be;
   logic [AW-1:0]     ram_a_addr;
   logic [DATA_W-1:0] ram_a_wdata, ram_a_rdata, ram_b_rdata;

   logic              rv1_q, rv1_d, err1_q, err1_d, oor1_q, oor1_d, byp1_q, byp1_d;
   logic [DATA_W-1:0] wd1_q, wd1_d;
   logic [BW-1:0]     be1_q, be1_d;
   logic              pv1_q, pv1_d, poor1_q, poor1_d;
   logic [DATA_W-1:0] rd1, pd1;

   // hold registers double as the second pipeline stage when OUT_REG is set
   logic [DATA_W-1:0] rhold_q, rhold_d, phold_q, phold_d;
   logic              rv2_q, rv2_d, err2_q, err2_d, pv2_q, pv2_d;

   always_comb begin
      main_inr = in_range(64'(bus.addr[ADDR_W-1:0]), DEPTH);
      peek_inr = in_range(64'(bus.peek_addr[ADDR_W-1:0]), DEPTH);
      main_ok  = !rst && (state_q == IDLE) && !bus.clr_req;

      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         INIT: begin
            state_d = (INIT_ZERO != 0) ? CLEAR : IDLE;
            ptr_d   = '0;
         end
         CLEAR: begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d = IDLE;
               ptr_d   = '0;
            end
         end
         IDLE: begin
            if (bus.clr_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         default: state_d = INIT;
      endcase

      // the sweep owns port A; reset must never disturb array contents
      if (state_q == CLEAR) begin
         ram_a_en    = !rst;
         ram_a_we    = !rst;
         ram_a_be    = '1;
         ram_a_addr  = ptr_q;
         ram_a_wdata = '0;
      end else begin
         ram_a_en    = main_ok && (bus.we || bus.re) && main_inr;
         ram_a_we    = main_ok && bus.we && main_inr;
         ram_a_be    = bus.be;
         ram_a_addr  = bus.addr[AW-1:0];
         ram_a_wdata = bus.wdata;
      end
      ram_b_en = bus.peek_req && peek_inr;

      rv1_d   = main_ok && bus.re;
      err1_d  = main_ok && (bus.we || bus.re) && !main_inr;
      oor1_d  = !main_inr;
      byp1_d  = (WR_FIRST != 0) && bus.we && bus.re;
      wd1_d   = bus.wdata;
      be1_d   = bus.be;
      pv1_d   = bus.peek_req;
      poor1_d = !peek_inr;

      if (oor1_q)      rd1 = '0;
      else if (byp1_q) rd1 = DATA_W'(byte_merge(MERGE_W'(ram_a_rdata), MERGE_W'(wd1_q),
                                                (MERGE_W/8)'(be1_q)));
      else             rd1 = ram_a_rdata;
      pd1 = poor1_q ? '0 : ram_b_rdata;

      rhold_d = rv1_q ? rd1 : rhold_q;
      phold_d = pv1_q ? pd1 : phold_q;
      rv2_d   = rv1_q;
      err2_d  = err1_q;
      pv2_d   = pv1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         ptr_q   <= '0;
         rv1_q   <= 1'b0;
         err1_q  <= 1'b0;
         oor1_q  <= 1'b0;
         byp1_q  <= 1'b0;
         wd1_q   <= '0;
         be1_q   <= '0;
         pv1_q   <= 1'b0;
         poor1_q <= 1'b0;
         rhold_q <= '0;
         phold_q <= '0;
         rv2_q   <= 1'b0;
         err2_q  <= 1'b0;
         pv2_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rv1_q   <= rv1_d;
         err1_q  <= err1_d;
         oor1_q  <= oor1_d;
         byp1_q  <= byp1_d;
         wd1_q   <= wd1_d;
         be1_q   <= be1_d;
         pv1_q   <= pv1_d;
         poor1_q <= poor1_d;
         rhold_q <= rhold_d;
         phold_q <= phold_d;
         rv2_q   <= rv2_d;
         err2_q  <= err2_d;
         pv2_q   <= pv2_d;
      end
   end

   node_ram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_array (
      .clk     (clk),
      .a_en    (ram_a_en),
      .a_we    (ram_a_we),
      .a_be    (ram_a_be),
      .a_addr  (ram_a_addr),
      .a_wdata (ram_a_wdata),
      .a_rdata (ram_a_rdata),
      .b_en    (ram_b_en),
      .b_addr  (bus.peek_addr[AW-1:0]),
      .b_rdata (ram_b_rdata)
   );

   assign bus.busy       = (state_q == CLEAR);
   assign bus.state      = state_q;
   assign bus.rdata      = (OUT_REG != 0) ? rhold_q : (rv1_q ? rd1 : rhold_q);
   assign bus.rvalid     = (OUT_REG != 0) ? rv2_q : rv1_q;
   assign bus.err        = (OUT_REG != 0) ? err2_q : err1_q;
   assign bus.peek_data  = (OUT_REG != 0) ? phold_q : (pv1_q ? pd1 : phold_q);
   assign bus.peek_valid = (OUT_REG != 0) ? pv2_q : pv1_q;

endmodule

// File: tb/tb_node_ram_ctrl.sv
// Directed bench: dut_a is latency-1 read-first, dut_b is latency-2 write-first; both DEPTH=16.
module tb_node_ram_ctrl;
   import node_mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   node_ram_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if_a ();
   node_ram_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if_b ();

   node_ram_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .OUT_REG(0), .WR_FIRST(0), .INIT_ZERO(1))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));
   node_ram_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .OUT_REG(1), .WR_FIRST(1), .INIT_ZERO(1))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));

   // ---------------- clock / drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic re, input logic clr,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
      if_a.we = we;   if_b.we = we;
      if_a.re = re;   if_b.re = re;
      if_a.clr_req = clr;  if_b.clr_req = clr;
      if_a.addr = addr;    if_b.addr = addr;
      if_a.wdata = wdata;  if_b.wdata = wdata;
      if_a.be = be;        if_b.be = be;
   endtask

   task automatic drive_peek(input logic req, input logic [31:0] addr);
      if_a.peek_req = req;   if_b.peek_req = req;
      if_a.peek_addr = addr; if_b.peek_addr = addr;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive_peek(1'b0, 32'h0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                           output logic ea, output logic eb);
      drive(1'b1, 1'b0, 1'b0, addr, data, be);
      tick();
      ea = if_a.err;
      idle();
      tick();
      eb = if_b.err;
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] da, output logic [31:0] db,
                          output logic lat_ok, output logic ea, output logic eb);
      logic av1, bv1, av2, bv2;
      drive(1'b0, 1'b1, 1'b0, addr, 32'h0, 4'h0);
      tick();
      av1 = if_a.rvalid; bv1 = if_b.rvalid; da = if_a.rdata; ea = if_a.err;
      idle();
      tick();
      av2 = if_a.rvalid; bv2 = if_b.rvalid; db = if_b.rdata; eb = if_b.err;
      lat_ok = (av1 === 1'b1) && (bv1 === 1'b0) && (av2 === 1'b0) && (bv2 === 1'b1);
   endtask

   task automatic do_peek(input logic [31:0] addr, output logic [31:0] pa, output logic [31:0] pb,
                          output logic lat_ok, output logic perr);
      logic av1, bv1, av2, bv2;
      drive_peek(1'b1, addr);
      tick();
      av1 = if_a.peek_valid; bv1 = if_b.peek_valid; pa = if_a.peek_data;
      perr = if_a.err | if_b.err;
      drive_peek(1'b0, 32'h0);
      tick();
      av2 = if_a.peek_valid; bv2 = if_b.peek_valid; pb = if_b.peek_data;
      perr = perr | if_a.err | if_b.err;
      lat_ok = (av1 === 1'b1) && (bv1 === 1'b0) && (av2 === 1'b0) && (bv2 === 1'b1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int ba, bb;
      logic [31:0] da, db;
      logic lat, ea, eb;
      ba = 0; bb = 0;
      rst = 1'b1;
      idle();
      repeat (3) tick();
      tests_run++;
      if (if_a.busy !== 1'b0 || if_b.busy !== 1'b0 || if_a.rvalid !== 1'b0 || if_b.rvalid !== 1'b0 ||
          if_a.rdata !== 32'h0 || if_b.rdata !== 32'h0 || if_a.err !== 1'b0 || if_b.err !== 1'b0 ||
          if_a.peek_valid !== 1'b0 || if_b.peek_valid !== 1'b0 ||
          if_a.peek_data !== 32'h0 || if_b.peek_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: busy=%b/%b rvalid=%b/%b rdata=%h/%h err=%b/%b pvalid=%b/%b expected all 0",
                  if_a.busy, if_b.busy, if_a.rvalid, if_b.rvalid, if_a.rdata, if_b.rdata,
                  if_a.err, if_b.err, if_a.peek_valid, if_b.peek_valid);
      end
      tests_run++;
      if (if_a.state !== INIT || if_b.state !== INIT) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d/%0d expected %0d", if_a.state, if_b.state, INIT);
      end
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (if_a.busy === 1'b1) ba++;
         if (if_b.busy === 1'b1) bb++;
         if (if_a.busy !== 1'b1 && if_b.busy !== 1'b1) break;
      end
      tests_run++;
      if (ba != 16 || bb != 16) begin
         tests_failed++;
         $display("FAIL auto_clear_busy_cycles: got %0d/%0d expected 16", ba, bb);
      end
      tests_run++;
      if (if_a.state !== IDLE || if_b.state !== IDLE) begin
         tests_failed++;
         $display("FAIL post_clear_state: got %0d/%0d expected %0d", if_a.state, if_b.state, IDLE);
      end
      for (int i = 0; i < 16; i++) begin
         do_read(32'(i), da, db, lat, ea, eb);
         tests_run++;
         if (da !== 32'h0 || db !== 32'h0 || lat !== 1'b1 || ea !== 1'b0 || eb !== 1'b0) begin
            tests_failed++;
            $display("FAIL cleared_word[%0d]: got %h/%h lat_ok=%b err=%b/%b expected 0 lat_ok=1 err=0",
                     i, da, db, lat, ea, eb);
         end
      end
   endtask

   task automatic test_byte_enable();
      logic [31:0] da, db;
      logic lat, ea, eb;
      do_write(32'd5, 32'hAABBCCDD, 4'b1111, ea, eb);
      do_write(32'd5, 32'h11223344, 4'b0101, ea, eb);
      do_read(32'd5, da, db, lat, ea, eb);
      tests_run++;
      if (da !== 32'hAA22CC44 || db !== 32'hAA22CC44) begin
         tests_failed++;
         $display("FAIL byte_enable_data: got %h/%h expected aa22cc44", da, db);
      end
      tests_run++;
      if (lat !== 1'b1 || ea !== 1'b0 || eb !== 1'b0) begin
         tests_failed++;
         $display("FAIL byte_enable_latency: lat_ok=%b err=%b/%b expected 1/0/0", lat, ea, eb);
      end
   endtask

   task automatic test_read_during_write();
      logic [31:0] da, db;
      logic lat, ea, eb, av, bv;
      do_write(32'd3, 32'h12345678, 4'hF, ea, eb);
      drive(1'b1, 1'b1, 1'b0, 32'd3, 32'hFFFF0000, 4'b1100);
      tick();
      da = if_a.rdata; av = if_a.rvalid;
      idle();
      tick();
      db = if_b.rdata; bv = if_b.rvalid;
      tests_run++;
      if (av !== 1'b1 || da !== 32'h12345678) begin
         tests_failed++;
         $display("FAIL rdw_read_first: got %h valid=%b expected 12345678 valid=1", da, av);
      end
      tests_run++;
      if (bv !== 1'b1 || db !== 32'hFFFF5678) begin
         tests_failed++;
         $display("FAIL rdw_write_first: got %h valid=%b expected ffff5678 valid=1", db, bv);
      end
      do_read(32'd3, da, db, lat, ea, eb);
      tests_run++;
      if (da !== 32'hFFFF5678 || db !== 32'hFFFF5678 || lat !== 1'b1) begin
         tests_failed++;
         $display("FAIL rdw_followup: got %h/%h lat_ok=%b expected ffff5678", da, db, lat);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] da, db;
      logic lat, ea, eb;
      do_write(32'd0, 32'h0BADF00D, 4'hF, ea, eb);
      do_write(32'd16, 32'hDEADBEEF, 4'hF, ea, eb);
      tests_run++;
      if (ea !== 1'b1 || eb !== 1'b1) begin
         tests_failed++;
         $display("FAIL oor_write_err: got %b/%b expected 1/1", ea, eb);
      end
      do_read(32'd16, da, db, lat, ea, eb);
      tests_run++;
      if (da !== 32'h0 || db !== 32'h0 || lat !== 1'b1 || ea !== 1'b1 || eb !== 1'b1) begin
         tests_failed++;
         $display("FAIL oor_read: got %h/%h lat_ok=%b err=%b/%b expected 0 lat_ok=1 err=1",
                  da, db, lat, ea, eb);
      end
      do_read(32'd0, da, db, lat, ea, eb);
      tests_run++;
      if (da !== 32'h0BADF00D || db !== 32'h0BADF00D || ea !== 1'b0 || eb !== 1'b0) begin
         tests_failed++;
         $display("FAIL oor_mem0_intact: got %h/%h err=%b/%b expected 0badf00d err=0", da, db, ea, eb);
      end
      do_read(32'h0001_0005, da, db, lat, ea, eb);
      tests_run++;
      if (da !== 32'h0 || db !== 32'h0 || ea !== 1'b1 || eb !== 1'b1) begin
         tests_failed++;
         $display("FAIL oor_upper_bits: got %h/%h err=%b/%b expected 0 err=1", da, db, ea, eb);
      end
   endtask

   task automatic test_peek();
      logic [31:0] pa, pb;
      logic lat, perr, av, bv;
      do_peek(32'd5, pa, pb, lat, perr);
      tests_run++;
      if (pa !== 32'hAA22CC44 || pb !== 32'hAA22CC44 || lat !== 1'b1) begin
         tests_failed++;
         $display("FAIL peek_data: got %h/%h lat_ok=%b expected aa22cc44 lat_ok=1", pa, pb, lat);
      end
      do_peek(32'd20, pa, pb, lat, perr);
      tests_run++;
      if (pa !== 32'h0 || pb !== 32'h0 || lat !== 1'b1 || perr !== 1'b0) begin
         tests_failed++;
         $display("FAIL peek_oor: got %h/%h lat_ok=%b err=%b expected 0 lat_ok=1 err=0", pa, pb, lat, perr);
      end
      drive(1'b1, 1'b0, 1'b0, 32'd5, 32'h55555555, 4'hF);
      drive_peek(1'b1, 32'd5);
      tick();
      pa = if_a.peek_data; av = if_a.peek_valid;
      idle();
      tick();
      pb = if_b.peek_data; bv = if_b.peek_valid;
      tests_run++;
      if (pa !== 32'hAA22CC44 || pb !== 32'hAA22CC44 || av !== 1'b1 || bv !== 1'b1) begin
         tests_failed++;
         $display("FAIL peek_during_write: got %h/%h valid=%b/%b expected aa22cc44", pa, pb, av, bv);
      end
      do_peek(32'd5, pa, pb, lat, perr);
      tests_run++;
      if (pa !== 32'h55555555 || pb !== 32'h55555555) begin
         tests_failed++;
         $display("FAIL peek_after_write: got %h/%h expected 55555555", pa, pb);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [4];
      logic ea, eb;
      for (int i = 0; i < 4; i++) begin
         exp_w[i] = 32'hB0B0_0000 + 32'(i * 3 + 1);
         do_write(32'(8 + i), exp_w[i], 4'hF, ea, eb);
      end
      for (int c = 0; c < 6; c++) begin
         if (c < 4) drive(1'b0, 1'b1, 1'b0, 32'(8 + c), 32'h0, 4'h0);
         else       idle();
         tick();
         tests_run++;
         if (c < 4) begin
            if (if_a.rvalid !== 1'b1 || if_a.rdata !== exp_w[c]) begin
               tests_failed++;
               $display("FAIL b2b_a[%0d]: got %h valid=%b expected %h valid=1", c, if_a.rdata, if_a.rvalid, exp_w[c]);
            end
         end else if (if_a.rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_a_tail[%0d]: got valid=%b expected 0", c, if_a.rvalid);
         end
         tests_run++;
         if (c >= 1 && c <= 4) begin
            if (if_b.rvalid !== 1'b1 || if_b.rdata !== exp_w[c-1]) begin
               tests_failed++;
               $display("FAIL b2b_b[%0d]: got %h valid=%b expected %h valid=1", c, if_b.rdata, if_b.rvalid, exp_w[c-1]);
            end
         end else if (if_b.rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_b_edge[%0d]: got valid=%b expected 0", c, if_b.rvalid);
         end
      end
   endtask

   task automatic test_clear();
      int ba, bb, rv_seen, er_seen;
      logic [31:0] pa, pb, da, db;
      logic lat, ea, eb;
      ba = 0; bb = 0; rv_seen = 0; er_seen = 0; pa = 32'h0; pb = 32'h0;
      for (int i = 0; i < 16; i++) do_write(32'(i), 32'hC0DE_0000 | 32'(i + 1), 4'hF, ea, eb);
      drive(1'b1, 1'b0, 1'b1, 32'd2, 32'hCAFEF00D, 4'hF);
      tick();
      for (int c = 0; c < 40; c++) begin
         if (if_a.busy === 1'b1) ba++;
         if (if_b.busy === 1'b1) bb++;
         if (if_a.rvalid !== 1'b0 || if_b.rvalid !== 1'b0) rv_seen++;
         if (if_a.err !== 1'b0 || if_b.err !== 1'b0) er_seen++;
         if (if_a.peek_valid === 1'b1) pa = if_a.peek_data;
         if (if_b.peek_valid === 1'b1) pb = if_b.peek_data;
         if (if_a.busy !== 1'b1 && if_b.busy !== 1'b1) break;
         drive(1'b0, 1'b1, (c == 5), 32'd4, 32'h0, 4'h0);
         drive_peek((c == 0), 32'd15);
         tick();
      end
      idle();
      tick();
      tests_run++;
      if (ba != 16 || bb != 16) begin
         tests_failed++;
         $display("FAIL clear_busy_cycles: got %0d/%0d expected 16", ba, bb);
      end
      tests_run++;
      if (rv_seen != 0 || er_seen != 0) begin
         tests_failed++;
         $display("FAIL clear_main_ignored: rvalid cycles=%0d err cycles=%0d expected 0/0", rv_seen, er_seen);
      end
      tests_run++;
      if (pa !== 32'hC0DE0010 || pb !== 32'hC0DE0010) begin
         tests_failed++;
         $display("FAIL clear_peek_old: got %h/%h expected c0de0010", pa, pb);
      end
      for (int i = 0; i < 16; i++) begin
         do_read(32'(i), da, db, lat, ea, eb);
         tests_run++;
         if (da !== 32'h0 || db !== 32'h0 || lat !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_word[%0d]: got %h/%h lat_ok=%b expected 0", i, da, db, lat);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      int ba, bb;
      logic [31:0] da, db;
      logic lat, ea, eb;
      ba = 0; bb = 0;
      for (int i = 10; i < 16; i++) do_write(32'(i), 32'h5A5A_0000 | 32'(i), 4'hF, ea, eb);
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      tick();
      idle();
      repeat (5) tick();
      drive_peek(1'b1, 32'd0);
      tick();
      tests_run++;
      if (if_a.busy !== 1'b1 || if_b.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL midclear_busy_before_rst: got %b/%b expected 1/1", if_a.busy, if_b.busy);
      end
      rst = 1'b1;
      drive_peek(1'b0, 32'd0);
      tick();
      tests_run++;
      if (if_a.busy !== 1'b0 || if_b.busy !== 1'b0 || if_a.rvalid !== 1'b0 || if_b.rvalid !== 1'b0 ||
          if_a.peek_valid !== 1'b0 || if_b.peek_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL midclear_rst_outputs: busy=%b/%b rvalid=%b/%b pvalid=%b/%b expected all 0",
                  if_a.busy, if_b.busy, if_a.rvalid, if_b.rvalid, if_a.peek_valid, if_b.peek_valid);
      end
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (if_a.busy === 1'b1) ba++;
         if (if_b.busy === 1'b1) bb++;
         if (if_a.busy !== 1'b1 && if_b.busy !== 1'b1) break;
      end
      tests_run++;
      if (ba != 16 || bb != 16) begin
         tests_failed++;
         $display("FAIL midclear_restart_cycles: got %0d/%0d expected 16", ba, bb);
      end
      for (int i = 10; i < 16; i++) begin
         do_read(32'(i), da, db, lat, ea, eb);
         tests_run++;
         if (da !== 32'h0 || db !== 32'h0 || lat !== 1'b1) begin
            tests_failed++;
            $display("FAIL midclear_word[%0d]: got %h/%h lat_ok=%b expected 0", i, da, db, lat);
         end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_byte_enable();
      test_read_during_write();
      test_out_of_range();
      test_peek();
      test_back_to_back();
      test_clear();
      test_reset_mid_clear();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/node_ram_ctrl.md
Name: node_ram_ctrl

Overview:
- Parametrised single-clock node memory with one read/write port and one independent read-only peek port.
- Adds byte-enable writes and a selectable read-during-write mode.
- Adds an optional output register, out-of-range address detection and a hardware clear engine.
- Sits beside each core as its local data/program store; the peek port is the debug/NoC observation path.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8.
- DEPTH, 1024, number of words.
- ADDR_W, 32, width of the address ports (word addresses).
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, latency 2.
- WR_FIRST, 0, 0 = read-first (rdata returns old word); 1 = write-first (rdata returns the merged new word).
- INIT_ZERO, 1, 1 = run the clear sweep automatically after reset.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous, active-high reset.
- clr_req, in, 1, one-cycle request to zero the whole array.
- busy, out, 1, clear sweep in progress.
- addr, in, ADDR_W, main-port word address.
- wdata, in, DATA_W, write data.
- be, in, DATA_W/8, byte enables.
- we, in, 1, write strobe.
- re, in, 1, read strobe.
- rdata, out, DATA_W, read data.
- rvalid, out, 1, rdata valid pulse.
- err, out, 1, out-of-range access pulse.
- peek_addr, in, ADDR_W, peek address.
- peek_req, in, 1, peek read strobe.
- peek_data, out, DATA_W, peek data.
- peek_valid, out, 1, peek data valid pulse.

Behaviour:
- **Reset (rst=1 at an edge):** rdata, peek_data = 0; rvalid, peek_valid, err = 0; busy = 0.
  - FSM goes to INIT and the clear pointer goes to 0.
  - Array contents are not modified by reset itself.
- **FSM states:** INIT, CLEAR, IDLE.
  - INIT -> CLEAR on the first edge with rst=0 if INIT_ZERO=1, otherwise INIT -> IDLE.
  - CLEAR writes 0 to mem[ptr] each cycle and increments ptr; when ptr == DEPTH-1 is written, go to IDLE. A sweep takes exactly DEPTH cycles.
  - IDLE -> CLEAR on clr_req=1 with ptr reset to 0.
  - busy = (state == CLEAR), decoded from the registered state.
- **While busy:**
  - we, re and clr_req on the main port are ignored: no write, no rvalid, no err.
  - The peek port stays operational and returns the array contents at that instant (partially cleared).
- **Main port in IDLE:**
  - Access is in range iff addr < DEPTH; upper address bits must be zero.
  - Write: for each byte i with be[i]=1, mem[addr] byte i <= wdata byte i. Bytes with be[i]=0 are unchanged.
  - Read: re=1 at edge N gives rvalid=1 at edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1), for exactly one cycle per accepted re.
  - rdata holds its value between reads.
  - Back-to-back reads are fully pipelined, one per cycle.
- **Simultaneous we and re, same address:**
  - WR_FIRST=0: rdata = the old word.
  - WR_FIRST=1: rdata = old word with the enabled bytes replaced by wdata.
- **Out of range** (we or re with addr >= DEPTH):
  - The write is suppressed and no array access occurs.
  - err=1 at the same latency slot as rvalid would have been.
  - A read in that case also gives rvalid=1 with rdata=0.
- **clr_req in IDLE with we or re in the same cycle:** clr_req wins. The access is dropped, with no rvalid and no err.
- **Peek port:**
  - peek_req=1 at edge N gives peek_valid=1 at the same latency as the main port.
  - Out-of-range peek_addr returns peek_data=0 with peek_valid=1 and no err.
  - Peek of an address written in the same cycle returns the old word.
- **Reset mid-operation:**
  - rst during CLEAR aborts the sweep, returns to INIT, and restarts from address 0 on release.
  - Read results still in the pipeline are discarded; rvalid and peek_valid are 0 after reset.
- **Initial contents:** a simulation-only optional INIT_FILE hook is permitted. The synthesised array has no power-up value guaranteed except through the clear engine.

Decomposition:
- Shared package node_mem_pkg:
  - fsm state enum (INIT, CLEAR, IDLE)
  - a byte-merge function (old, new, be) -> merged word
  - an in-range helper parametrised by DEPTH
- Natural sub-module: node_ram_array.
  - Pure storage with one byte-enabled write/read port and one read port, latency 1, read-first.
  - Holds the inferred memory so it maps to block RAM.
- node_ram_ctrl wraps node_ram_array with:
  - the FSM and clear pointer
  - range checks
  - write-first bypass
  - the optional output stage

Test Plan:
- **Reset and auto-clear:** rst 3 cycles then release with DEPTH=16, INIT_ZERO=1 -> busy=1 for exactly 16 cycles. Afterwards, re to all addresses 0..15 returns rdata=0x00000000.
- **Byte-enable write:** write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101, then read addr 5 -> rdata=0xAA22CC44. rvalid appears 1 cycle after re (OUT_REG=0) and 2 cycles after re (OUT_REG=1).
- **Read-during-write:** mem[3]=0x12345678; same cycle we=1, re=1, addr=3, wdata=0xFFFF0000, be=4'b1100.
  - WR_FIRST=0 -> rdata=0x12345678.
  - WR_FIRST=1 -> rdata=0xFFFF5678.
  - Both cases: a subsequent read returns 0xFFFF5678.
- **Out of range:** DEPTH=16, we to addr 16 with data 0xDEADBEEF, then re addr 16 -> err pulses for each access, rdata=0 with rvalid=1, and mem[0] is unchanged.
- **clr_req and busy interplay:** fill addr 0..15 with nonzero data, pulse clr_req together with we at addr 2 -> the write is dropped. During the sweep, re is ignored (rvalid stays 0) and peek of addr 15 returns the old value. After 16 cycles all words read 0.
- **Reset mid-clear:** assert rst at sweep cycle 7 for 1 cycle -> rvalid=0 and busy=0 during rst, then a full 16-cycle sweep restarts from address 0.
